// File: rtl/mips_muldiv_unit.sv
// MIPS HI/LO multiply/divide unit.
// Multiplies complete after a fixed MUL_LAT cycles. Divides use a restoring
// divider that produces one quotient bit per cycle, followed by a FIX cycle
// that applies the result signs. MTHI/MTLO write HI/LO directly while idle.
module mips_muldiv_unit #(
   parameter int DATA_W  = 32,
   parameter int MUL_LAT = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [2:0]        op,
   input  logic [DATA_W-1:0] src_a,
   input  logic [DATA_W-1:0] src_b,
   input  logic              flush,
   input  logic              hilo_rd,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo,
   output logic              busy,
   output logic              stall_req,
   output logic              done,
   output logic              div_by_zero
);

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   // The counter only ever holds MUL_LAT-1 (at most 7) or DATA_W-1.
   localparam int               CNT_W        = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] MUL_CNT_INIT = CNT_W'(MUL_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_CNT_INIT = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MUL,
      ST_DIV,
      ST_FIX
   } state_t;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   hi_q, hi_d;
   logic [DATA_W-1:0]   lo_q, lo_d;
   logic                done_q, done_d;
   logic                dz_q, dz_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   a_q, a_d;      // raw first operand
   logic [DATA_W-1:0]   b_q, b_d;      // multiplier, or divisor magnitude
   logic [DATA_W-1:0]   rem_q, rem_d;  // partial remainder
   logic [DATA_W-1:0]   quo_q, quo_d;  // dividend shifting out, quotient shifting in
   logic                signed_q, signed_d;
   logic                q_neg_q, q_neg_d;

   // Operand conditioning for a divide being accepted this cycle.
   logic              div_signed;
   logic              a_neg;
   logic              b_neg;
   logic [DATA_W-1:0] mag_a;
   logic [DATA_W-1:0] mag_b;

   assign div_signed = (op == OP_DIV);
   assign a_neg      = div_signed & src_a[DATA_W-1];
   assign b_neg      = div_signed & src_b[DATA_W-1];
   assign mag_a      = a_neg ? -src_a : src_a;
   assign mag_b      = b_neg ? -src_b : src_b;

   // Full-width product; extending both operands to 2*DATA_W makes the
   // truncated unsigned multiply equal to the signed product for MULT.
   logic [2*DATA_W-1:0] a_ext;
   logic [2*DATA_W-1:0] b_ext;
   logic [2*DATA_W-1:0] prod;

   assign a_ext = {{DATA_W{signed_q & a_q[DATA_W-1]}}, a_q};
   assign b_ext = {{DATA_W{signed_q & b_q[DATA_W-1]}}, b_q};
   assign prod  = a_ext * b_ext;

   // One restoring step: shift in the next dividend bit, try a subtract.
   logic [DATA_W:0] rem_shift;
   logic [DATA_W:0] rem_diff;

   assign rem_shift = {rem_q, quo_q[DATA_W-1]};
   assign rem_diff  = rem_shift - {1'b0, b_q};

   // Sign fix-up: quotient sign is sign(a)^sign(b), remainder follows a.
   logic              r_neg;
   logic [DATA_W-1:0] quo_fix;
   logic [DATA_W-1:0] rem_fix;

   assign r_neg   = signed_q & a_q[DATA_W-1];
   assign quo_fix = q_neg_q ? -quo_q : quo_q;
   assign rem_fix = r_neg ? -rem_q : rem_q;

   // Next-state, datapath and HI/LO update logic.
   always_comb begin
      // NOTE: every signal driven here gets a hold/default value first, so
      // no path through the case leaves it unassigned and no latch is built.
      state_d  = state_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;
      dz_d     = 1'b0;
      cnt_d    = cnt_q;
      a_d      = a_q;
      b_d      = b_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      signed_d = signed_q;
      q_neg_d  = q_neg_q;

      case (state_q)
         ST_IDLE: begin
            if (start && !flush) begin
               case (op)
                  OP_MTHI: hi_d = src_a;
                  OP_MTLO: lo_d = src_a;
                  OP_MULT, OP_MULTU: begin
                     a_d      = src_a;
                     b_d      = src_b;
                     signed_d = (op == OP_MULT);
                     cnt_d    = MUL_CNT_INIT;
                     state_d  = ST_MUL;
                  end
                  OP_DIV, OP_DIVU: begin
                     a_d      = src_a;
                     b_d      = mag_b;
                     quo_d    = mag_a;
                     rem_d    = '0;
                     signed_d = div_signed;
                     q_neg_d  = a_neg ^ b_neg;
                     cnt_d    = DIV_CNT_INIT;
                     state_d  = ST_DIV;
                  end
                  default: ;  // 110/111 are no-ops
               endcase
            end
         end

         ST_MUL: begin
            if (flush) begin
               state_d = ST_IDLE;
            end else if (cnt_q == '0) begin
               {hi_d, lo_d} = prod;
               done_d       = 1'b1;
               state_d      = ST_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         ST_DIV: begin
            if (flush) begin
               state_d = ST_IDLE;
            end else begin
               if (!rem_diff[DATA_W]) begin
                  rem_d = rem_diff[DATA_W-1:0];
                  quo_d = {quo_q[DATA_W-2:0], 1'b1};
               end else begin
                  rem_d = rem_shift[DATA_W-1:0];
                  quo_d = {quo_q[DATA_W-2:0], 1'b0};
               end
               if (cnt_q == '0) begin
                  state_d = ST_FIX;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
         end

         ST_FIX: begin
            if (flush) begin
               state_d = ST_IDLE;
            end else begin
               // A zero divisor reports all-ones quotient and the raw dividend.
               if (b_q == '0) begin
                  lo_d = '1;
                  hi_d = a_q;
                  dz_d = 1'b1;
               end else begin
                  lo_d = quo_fix;
                  hi_d = rem_fix;
               end
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // State, HI/LO and datapath registers with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: non-blocking assignments here so every register samples the
      // values from before the edge, independent of statement order.
      if (reset) begin
         state_q  <= ST_IDLE;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
         dz_q     <= 1'b0;
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         signed_q <= 1'b0;
         q_neg_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         done_q   <= done_d;
         dz_q     <= dz_d;
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         b_q      <= b_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         signed_q <= signed_d;
         q_neg_q  <= q_neg_d;
      end
   end

   assign hi          = hi_q;
   assign lo          = lo_q;
   assign busy        = (state_q != ST_IDLE);
   assign stall_req   = busy & (hilo_rd | start);
   assign done        = done_q;
   assign div_by_zero = dz_q;

endmodule

// File: doc/mips_muldiv_unit.md
MIPS_MULDIV_UNIT -- requirements
Module: mips_muldiv_unit

Parameters
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the operand and HI/LO width; legal values are even numbers of 8 or more.
REQ-002 The block SHALL have parameter MUL_LAT, default 3, giving the multiply latency in cycles; legal range is 1..8.

Interface
REQ-003 The block SHALL have port clk, input, width 1: the single clock, rising-edge active.
REQ-004 The block SHALL have port reset, input, width 1: asynchronous, active-high reset.
REQ-005 The block SHALL have port start, input, width 1: request to launch the operation given by op.
REQ-006 The block SHALL have port op, input, width 3: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; codes 110 and 111 are no-ops.
REQ-007 The block SHALL have port src_a, input, width DATA_W: the multiplicand, dividend or move source.
REQ-008 The block SHALL have port src_b, input, width DATA_W: the multiplier or divisor.
REQ-009 The block SHALL have port flush, input, width 1: abort of any in-flight operation.
REQ-010 The block SHALL have port hilo_rd, input, width 1: an MFHI or MFLO instruction is present in the decode stage.
REQ-011 The block SHALL have port hi, output, width DATA_W: the architectural HI register.
REQ-012 The block SHALL have port lo, output, width DATA_W: the architectural LO register.
REQ-013 The block SHALL have port busy, output, width 1: high while the state is MUL, DIV or FIX.
REQ-014 The block SHALL have port stall_req, output, width 1: combinational busy & (hilo_rd | start), routed to the hazard unit.
REQ-015 The block SHALL have port done, output, width 1: registered one-cycle pulse when HI/LO are written by MULT, MULTU, DIV or DIVU.
REQ-016 The block SHALL have port div_by_zero, output, width 1: registered; valid only while done is high.

Function
REQ-017 The state machine SHALL have states IDLE, MUL, DIV and FIX.
REQ-018 start SHALL be accepted only in IDLE; start in any other state is ignored, and the pipeline holds start stable by means of stall_req.
REQ-019 MTHI or MTLO accepted at edge E SHALL write src_a into hi or lo at edge E; the state stays IDLE, busy stays low and done is not asserted.
REQ-020 MULT or MULTU accepted at edge E SHALL enter MUL; at edge E+MUL_LAT the block writes {hi,lo} = the 2*DATA_W-bit product (signed for MULT, unsigned for MULTU), pulses done for one cycle and returns to IDLE.
REQ-021 DIV or DIVU accepted at edge E SHALL latch the operand magnitudes (absolute values for DIV) and the result signs, then enter DIV.
REQ-022 In DIV, one restoring quotient bit SHALL be produced per edge; after DATA_W iterations (edge E+DATA_W) the state moves to FIX.
REQ-023 In FIX, at edge E+DATA_W+1, the block SHALL apply the signs and write lo = quotient and hi = remainder, pulse done and return to IDLE.
REQ-024 For DIV, the quotient sign SHALL be sign(a) XOR sign(b) and the remainder sign SHALL be sign(a).
REQ-025 For DIV with a = most-negative and b = -1, the result SHALL be lo = 0x80000000 and hi = 0 at DATA_W = 32.
REQ-026 For divide by zero (src_b = 0), the block SHALL take the full DIV latency and then give lo = all ones, hi = src_a unmodified, with div_by_zero = 1 alongside done.
REQ-027 flush in any non-IDLE state SHALL force IDLE at the next edge; hi and lo are left unchanged and done is not pulsed.
REQ-028 flush in IDLE SHALL suppress acceptance of a simultaneous start.
REQ-029 In the cycle where done is high the state SHALL already be IDLE, so a new start is accepted in that same cycle.
REQ-030 hi and lo SHALL change only as described in REQ-019, REQ-020 and REQ-023.

Reset
REQ-031 reset SHALL asynchronously force state = IDLE and hi = lo = 0, with busy, done and div_by_zero all 0.
REQ-032 reset during MUL or DIV SHALL abort the operation; no done pulse follows the deassertion of reset.

Verification
REQ-033 MULT with src_a = 0xFFFFFFFE (-2) and src_b = 3 at MUL_LAT = 3 -> done 3 cycles after accept; hi = 0xFFFFFFFF, lo = 0xFFFFFFFA.
REQ-034 DIV with src_a = -7 and src_b = 2 -> done 33 cycles after accept; lo = 0xFFFFFFFD, hi = 0xFFFFFFFF; DIVU with src_a = 7 and src_b = 2 -> lo = 3, hi = 1.
REQ-035 DIVU with src_a = 0x12345678 and src_b = 0 -> after 33 cycles, done and div_by_zero both high; lo = 0xFFFFFFFF, hi = 0x12345678.
REQ-036 DIV started, hilo_rd asserted at cycle 5 -> stall_req = 1 until done; flush at cycle 10 -> IDLE next cycle, HI/LO keep their prior values, no done pulse.
REQ-037 MTHI with src_a = 0xA5A5A5A5 -> hi = 0xA5A5A5A5 at the same edge, busy stays 0; a back-to-back MULTU is then accepted in the next cycle.
REQ-038 reset asserted mid-DIV (iteration 12) -> all outputs go to 0 immediately; after release, start is accepted in the first cycle.
